// File: rtl/instructions_pkg.sv
// Shared RV32I decode constants, funct3 encodings and the memory-stage FSM state type.
package instructions_pkg;
   localparam int XLEN         = 32;
   localparam int MSB_REG_FILE = 5;
   localparam int INST_WIDTH   = 32;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   // Size comes from funct3[1:0]; any non byte/half encoding is handled as a word.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   return 1'b0;
         2'b01:   return off[0];
         default: return off != 2'b00;
      endcase
   endfunction
endpackage

// File: rtl/mem_access_load_align.sv
// Load data extraction: shifts the addressed lane down and sign/zero-extends per funct3.
module load_align
   import instructions_pkg::*;
#(
   parameter int XLEN = instructions_pkg::XLEN
) (
   input  logic [XLEN-1:0] rdata_i,
   input  logic [1:0]      off_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o
);
   logic [XLEN-1:0] shifted;

   assign shifted = rdata_i >> {off_i, 3'b000};

   always_comb begin
      data_o = rdata_i;
      case (funct3_i)
         F3_B:    data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         F3_BU:   data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
         F3_H:    data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_HU:   data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: data_o = rdata_i;
      endcase
   end
endmodule

// File: rtl/mem_access.sv
// RV32I memory-access stage: issues loads/stores on the data port, aligns load data,
// and registers one write-back result per accepted instruction.
module mem_access
   import instructions_pkg::*;
#(
   parameter int XLEN         = instructions_pkg::XLEN,
   parameter int MSB_REG_FILE = instructions_pkg::MSB_REG_FILE,
   parameter int INST_WIDTH   = instructions_pkg::INST_WIDTH
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    ex_valid,
   output logic                    ex_ready,
   input  logic [XLEN-1:0]         alu_data,
   input  logic [XLEN-1:0]         store_data,
   input  logic [MSB_REG_FILE-1:0] rd,
   input  logic [INST_WIDTH-1:0]   ir,
   output logic                    dmem_req,
   output logic                    dmem_we,
   output logic [XLEN-1:0]         dmem_addr,
   output logic [XLEN-1:0]         dmem_wdata,
   output logic [3:0]              dmem_be,
   input  logic                    dmem_gnt,
   input  logic                    dmem_rvalid,
   input  logic [XLEN-1:0]         dmem_rdata,
   output logic                    wb_valid,
   output logic [XLEN-1:0]         wb_data,
   output logic [MSB_REG_FILE-1:0] wb_rd,
   output logic [INST_WIDTH-1:0]   wb_ir,
   output logic                    wb_we,
   output logic                    misaligned
);
   state_e                  st_q;
   logic                    req_q, we_q;
   logic [XLEN-1:0]         addr_q, wdata_q;
   logic [3:0]              be_q;
   logic [1:0]              off_q;
   logic [2:0]              f3_q;
   logic                    wb_valid_q, wb_we_q, mis_q;
   logic [XLEN-1:0]         wb_data_q;
   logic [MSB_REG_FILE-1:0] wb_rd_q;
   logic [INST_WIDTH-1:0]   wb_ir_q;

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [1:0]      off;
   logic            is_load, is_store;
   logic [3:0]      be_d;
   logic [XLEN-1:0] wdata_d, ld_data;

   assign opc      = ir[6:0];
   assign f3       = ir[14:12];
   assign off      = alu_data[1:0];
   assign is_load  = (opc == OP_LOAD);
   assign is_store = (opc == OP_STORE);

   always_comb begin
      be_d    = 4'b1111;
      wdata_d = store_data;
      case (f3[1:0])
         2'b00: begin
            be_d    = 4'b0001 << off;
            wdata_d = {4{store_data[7:0]}};
         end
         2'b01: begin
            be_d    = 4'b0011 << off;
            wdata_d = {2{store_data[15:0]}};
         end
         default: ;
      endcase
   end

   load_align #(.XLEN(XLEN)) u_load_align (
      .rdata_i  (dmem_rdata),
      .off_i    (off_q),
      .funct3_i (f3_q),
      .data_o   (ld_data)
   );

   // rd and ir are captured straight into the write-back registers at accept time,
   // so they double as the in-flight instruction context.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st_q       <= S_IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         off_q      <= '0;
         f3_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         mis_q      <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
         wb_ir_q    <= '0;
      end else begin
         wb_valid_q <= 1'b0;
         mis_q      <= 1'b0;
         case (st_q)
            S_IDLE: begin
               if (ex_valid) begin
                  wb_data_q <= alu_data;
                  wb_rd_q   <= rd;
                  wb_ir_q   <= ir;
                  if (!(is_load || is_store)) begin
                     wb_valid_q <= 1'b1;
                     wb_we_q    <= (opc != OP_BRANCH) && (rd != '0);
                  end else if (is_misaligned(f3, off)) begin
                     wb_valid_q <= 1'b1;
                     wb_we_q    <= 1'b0;
                     mis_q      <= 1'b1;
                  end else begin
                     req_q   <= 1'b1;
                     we_q    <= is_store;
                     addr_q  <= {alu_data[XLEN-1:2], 2'b00};
                     be_q    <= be_d;
                     wdata_q <= is_store ? wdata_d : '0;
                     off_q   <= off;
                     f3_q    <= f3;
                     st_q    <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (dmem_gnt) begin
                  req_q <= 1'b0;
                  if (we_q) begin
                     wb_valid_q <= 1'b1;
                     wb_we_q    <= 1'b0;
                     st_q       <= S_IDLE;
                  end else if (dmem_rvalid) begin
                     wb_valid_q <= 1'b1;
                     wb_we_q    <= (wb_rd_q != '0);
                     wb_data_q  <= ld_data;
                     st_q       <= S_IDLE;
                  end else begin
                     st_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (dmem_rvalid) begin
                  wb_valid_q <= 1'b1;
                  wb_we_q    <= (wb_rd_q != '0);
                  wb_data_q  <= ld_data;
                  st_q       <= S_IDLE;
               end
            end
            default: st_q <= S_IDLE;
         endcase
      end
   end

   assign ex_ready   = rstn && (st_q == S_IDLE);
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign dmem_be    = be_q;
   assign wb_valid   = wb_valid_q;
   assign wb_data    = wb_data_q;
   assign wb_rd      = wb_rd_q;
   assign wb_ir      = wb_ir_q;
   assign wb_we      = wb_we_q;
   assign misaligned = mis_q;
endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed stimulus pushes expected write-backs,
// a negedge monitor pops and compares every wb_valid pulse.
module tb_mem_access;
   logic        clk = 1'b0, rstn = 1'b0;
   logic        ex_valid = 1'b0, ex_ready;
   logic [31:0] alu_data = '0, store_data = '0, ir = '0;
   logic [4:0]  rd = '0;
   logic        dmem_req, dmem_we, dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
   logic [3:0]  dmem_be;
   logic        wb_valid, wb_we, misaligned;
   logic [31:0] wb_data, wb_ir;
   logic [4:0]  wb_rd;

   localparam logic [6:0] OPC_LD = 7'b0000011, OPC_ST = 7'b0100011;
   localparam logic [6:0] OPC_BR = 7'b1100011, OPC_ALU = 7'b0110011, OPC_LUI = 7'b0110111;

   mem_access dut (
      .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .alu_data(alu_data), .store_data(store_data), .rd(rd), .ir(ir),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_ir(wb_ir),
      .wb_we(wb_we), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic [31:0] ir;
      logic        we;
      logic        mis;
      logic        cd;
   } exp_t;

   exp_t q[$];
   int   checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk_ir(input logic [6:0] opc, input logic [2:0] f3);
      return {17'd0, f3, 5'd0, opc};
   endfunction

   task automatic expect_wb(input logic [31:0] d, input logic [4:0] r, input logic [31:0] i,
                            input logic we, input logic mis, input logic cd);
      exp_t e;
      e.data = d; e.rd = r; e.ir = i; e.we = we; e.mis = mis; e.cd = cd;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rstn) begin
         if (wb_valid) begin
            chk("wb_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
               e = q.pop_front();
               if (e.cd) chk("wb_data", wb_data, e.data);
               chk("wb_rd", 32'(wb_rd), 32'(e.rd));
               chk("wb_ir", wb_ir, e.ir);
               chk("wb_we", 32'(wb_we), 32'(e.we));
               chk("misaligned", 32'(misaligned), 32'(e.mis));
            end
         end else if (misaligned) begin
            chk("mis_has_wb", 32'(wb_valid), 32'd1);
         end
      end
   end

   // Presents one instruction and holds it until the accepting edge.
   task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] r,
                        input logic [31:0] a, input logic [31:0] sd);
      ex_valid = 1'b1; ir = mk_ir(opc, f3); rd = r; alu_data = a; store_data = sd;
      @(negedge clk);
      chk("ex_ready_accept", 32'(ex_ready), 32'd1);
      @(posedge clk); #1;
      ex_valid = 1'b0;
   endtask

   task automatic chk_dmem(input logic we, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd);
      chk("dmem_req", 32'(dmem_req), 32'd1);
      chk("dmem_we", 32'(dmem_we), 32'(we));
      chk("dmem_addr", dmem_addr, a);
      chk("dmem_be", 32'(dmem_be), 32'(be));
      if (we) chk("dmem_wdata", dmem_wdata, wd);
   endtask

   // gd: cycles before gnt; rvd: 0 = rvalid with gnt, >0 = cycles in WAIT, <0 = store.
   task automatic mem_op(input int gd, input int rvd, input logic [31:0] rdat);
      for (int i = 0; i < gd; i++) begin
         @(negedge clk);
         chk("req_held", 32'(dmem_req), 32'd1);
         chk("ready_low_req", 32'(ex_ready), 32'd0);
         @(posedge clk); #1;
      end
      dmem_gnt = 1'b1;
      if (rvd == 0) begin dmem_rvalid = 1'b1; dmem_rdata = rdat; end
      @(negedge clk);
      chk("req_at_gnt", 32'(dmem_req), 32'd1);
      @(posedge clk); #1;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (rvd > 0) begin
         for (int i = 0; i < rvd; i++) begin
            @(negedge clk);
            chk("req_low_wait", 32'(dmem_req), 32'd0);
            chk("ready_low_wait", 32'(ex_ready), 32'd0);
            @(posedge clk); #1;
         end
         dmem_rvalid = 1'b1; dmem_rdata = rdat;
         @(posedge clk); #1;
         dmem_rvalid = 1'b0;
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_ex_ready", 32'(ex_ready), 32'd0);
      chk("rst_dmem_req", 32'(dmem_req), 32'd0);
      chk("rst_dmem_we", 32'(dmem_we), 32'd0);
      chk("rst_dmem_addr", dmem_addr, 32'd0);
      chk("rst_dmem_be", 32'(dmem_be), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_misaligned", 32'(misaligned), 32'd0);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", 32'(ex_ready), 32'd1);

      // pass-through, back to back
      expect_wb(32'h0000_1234, 5'd5, mk_ir(OPC_ALU, 3'd0), 1'b1, 1'b0, 1'b1);
      issue(OPC_ALU, 3'd0, 5'd5, 32'h0000_1234, 32'h0);
      expect_wb(32'hDEAD_0000, 5'd0, mk_ir(OPC_LUI, 3'd0), 1'b0, 1'b0, 1'b1);
      issue(OPC_LUI, 3'd0, 5'd0, 32'hDEAD_0000, 32'h0);
      expect_wb(32'h0000_0040, 5'd3, mk_ir(OPC_BR, 3'd1), 1'b0, 1'b0, 1'b1);
      issue(OPC_BR, 3'd1, 5'd3, 32'h0000_0040, 32'h0);

      // LB, gnt and rvalid each delayed two cycles
      expect_wb(32'hFFFF_FF80, 5'd7, mk_ir(OPC_LD, 3'b000), 1'b1, 1'b0, 1'b1);
      issue(OPC_LD, 3'b000, 5'd7, 32'h0000_0103, 32'h0);
      chk_dmem(1'b0, 32'h0000_0100, 4'b1000, 32'h0);
      mem_op(2, 2, 32'h80FF_0000);

      // LHU with gnt+rvalid together
      expect_wb(32'h0000_BEEF, 5'd9, mk_ir(OPC_LD, 3'b101), 1'b1, 1'b0, 1'b1);
      issue(OPC_LD, 3'b101, 5'd9, 32'h0000_0102, 32'h0);
      chk_dmem(1'b0, 32'h0000_0100, 4'b1100, 32'h0);
      mem_op(0, 0, 32'hBEEF_0000);

      expect_wb(32'hFFFF_8001, 5'd10, mk_ir(OPC_LD, 3'b001), 1'b1, 1'b0, 1'b1);
      issue(OPC_LD, 3'b001, 5'd10, 32'h0000_0102, 32'h0);
      mem_op(1, 1, 32'h8001_0000);

      expect_wb(32'h0000_0056, 5'd11, mk_ir(OPC_LD, 3'b100), 1'b1, 1'b0, 1'b1);
      issue(OPC_LD, 3'b100, 5'd11, 32'h0000_0111, 32'h0);
      mem_op(0, 0, 32'h1234_5678);

      expect_wb(32'h1234_5678, 5'd0, mk_ir(OPC_LD, 3'b010), 1'b0, 1'b0, 1'b1);
      issue(OPC_LD, 3'b010, 5'd0, 32'h0000_0104, 32'h0);
      chk_dmem(1'b0, 32'h0000_0104, 4'b1111, 32'h0);
      mem_op(0, 1, 32'h1234_5678);

      // stores
      expect_wb(32'h0, 5'd0, mk_ir(OPC_ST, 3'b000), 1'b0, 1'b0, 1'b0);
      issue(OPC_ST, 3'b000, 5'd0, 32'h0000_0201, 32'h0000_00AB);
      chk_dmem(1'b1, 32'h0000_0200, 4'b0010, 32'hABAB_ABAB);
      mem_op(1, -1, 32'h0);

      expect_wb(32'h0, 5'd2, mk_ir(OPC_ST, 3'b001), 1'b0, 1'b0, 1'b0);
      issue(OPC_ST, 3'b001, 5'd2, 32'h0000_0202, 32'h1234_CDEF);
      chk_dmem(1'b1, 32'h0000_0200, 4'b1100, 32'hCDEF_CDEF);
      mem_op(0, -1, 32'h0);

      expect_wb(32'h0, 5'd0, mk_ir(OPC_ST, 3'b010), 1'b0, 1'b0, 1'b0);
      issue(OPC_ST, 3'b010, 5'd0, 32'h0000_0200, 32'hCAFE_F00D);
      chk_dmem(1'b1, 32'h0000_0200, 4'b1111, 32'hCAFE_F00D);
      mem_op(0, -1, 32'h0);

      // misaligned word store and halfword load
      expect_wb(32'h0, 5'd0, mk_ir(OPC_ST, 3'b010), 1'b0, 1'b1, 1'b0);
      issue(OPC_ST, 3'b010, 5'd0, 32'h0000_0202, 32'h1111_2222);
      @(negedge clk);
      chk("mis_no_req", 32'(dmem_req), 32'd0);
      chk("mis_ready", 32'(ex_ready), 32'd1);
      @(posedge clk); #1;
      expect_wb(32'h0, 5'd6, mk_ir(OPC_LD, 3'b001), 1'b0, 1'b1, 1'b0);
      issue(OPC_LD, 3'b001, 5'd6, 32'h0000_0101, 32'h0);
      @(negedge clk);
      chk("mis_ld_no_req", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;

      // reset while in WAIT; late rvalid must be dropped
      issue(OPC_LD, 3'b010, 5'd4, 32'h0000_0300, 32'h0);
      dmem_gnt = 1'b1;
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
      @(negedge clk);
      chk("wait_ready_low", 32'(ex_ready), 32'd0);
      rstn = 1'b0; #1;
      chk("rst_wait_req", 32'(dmem_req), 32'd0);
      chk("rst_wait_ready", 32'(ex_ready), 32'd0);
      #2 rstn = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_rst", 32'(ex_ready), 32'd1);
      dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;

      // reset while in REQ drops the request at once
      issue(OPC_ST, 3'b010, 5'd0, 32'h0000_0500, 32'h7777_7777);
      chk("req_before_rst", 32'(dmem_req), 32'd1);
      #2 rstn = 1'b0; #1;
      chk("rst_req_drop", 32'(dmem_req), 32'd0);
      #2 rstn = 1'b1;
      dmem_gnt = 1'b1;
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
      chk("req_stays_low", 32'(dmem_req), 32'd0);
      chk("ready_after_req_rst", 32'(ex_ready), 32'd1);

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
